// File: rtl/ysyx_22050612_mem_pkg.sv
// Shared types and width defaults for the data-memory arbiter.
package ysyx_22050612_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  localparam int DEF_ADDR_W = 64;
  localparam int DEF_DATA_W = 64;
  localparam int DEF_MASK_W = DEF_DATA_W / 8;

endpackage

// File: rtl/ysyx_22050612_rr_arb2.sv
// Two-way round-robin arbiter; prio names the requester favoured on contention.
module ysyx_22050612_rr_arb2
  import ysyx_22050612_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  owner_e prio;

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = (prio == OWN_IF) ? 2'b01 : 2'b10;
  end

  // The loser of a grant becomes the favoured requester next time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio <= OWN_IF;
    end else if (advance && gnt[0]) begin
      prio <= OWN_LS;
    end else if (advance && gnt[1]) begin
      prio <= OWN_IF;
    end
  end

endmodule

// File: rtl/ysyx_22050612_mem_arbiter.sv
// Shares one handshaked memory port between IFU reads and LSU reads/writes,
// one transaction outstanding, with a watchdog that aborts unanswered requests.
module ysyx_22050612_mem_arbiter #(
  parameter int ADDR_W  = ysyx_22050612_mem_pkg::DEF_ADDR_W,
  parameter int DATA_W  = ysyx_22050612_mem_pkg::DEF_DATA_W,
  parameter int MASK_W  = ysyx_22050612_mem_pkg::DEF_MASK_W,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_wen,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  input  logic [MASK_W-1:0] ls_wmask,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_req,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_wmask,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_err
);
  import ysyx_22050612_mem_pkg::*;

  localparam logic [7:0] TO = 8'(TIMEOUT);

  state_e     state;
  owner_e     owner;
  logic [7:0] cnt;
  logic [1:0] arb_gnt;
  logic       idle, busy, timeout, rsp_ok, done;

  assign idle    = (state == IDLE);
  assign busy    = (state == REQ) || (state == WAIT);
  assign timeout = busy && (cnt == TO);
  // A real response beats a coincident timeout; rvalid during REQ is ignored.
  assign rsp_ok  = (state == WAIT) && mem_rvalid;
  assign done    = rsp_ok || timeout;

  ysyx_22050612_rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({ls_req, if_req} & {2{idle}}),
    .advance (idle),
    .gnt     (arb_gnt)
  );

  assign if_gnt    = rst_n && arb_gnt[0];
  assign ls_gnt    = rst_n && arb_gnt[1];
  assign if_rvalid = rst_n && done && (owner == OWN_IF);
  assign ls_rvalid = rst_n && done && (owner == OWN_LS);
  assign if_rdata  = (rsp_ok && owner == OWN_IF) ? mem_rdata : '0;
  assign ls_rdata  = (rsp_ok && owner == OWN_LS) ? mem_rdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= OWN_IF;
      cnt       <= 8'd0;
      mem_err   <= 1'b0;
      mem_req   <= 1'b0;
      mem_wen   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wmask <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|arb_gnt) begin
            state   <= REQ;
            mem_req <= 1'b1;
            cnt     <= 8'd0;
            if (arb_gnt[1]) begin
              owner     <= OWN_LS;
              mem_wen   <= ls_wen;
              mem_addr  <= ls_addr;
              mem_wdata <= ls_wdata;
              mem_wmask <= ls_wmask;
            end else begin
              owner     <= OWN_IF;
              mem_wen   <= 1'b0;
              mem_addr  <= if_addr;
              mem_wdata <= '0;
              mem_wmask <= '0;
            end
          end
        end
        REQ: begin
          cnt <= cnt + 8'd1;
          if (timeout) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            mem_err <= 1'b1;
          end else if (mem_gnt) begin
            state   <= WAIT;
            mem_req <= 1'b0;
          end
        end
        WAIT: begin
          cnt <= cnt + 8'd1;
          if (rsp_ok) begin
            state <= IDLE;
          end else if (timeout) begin
            state   <= IDLE;
            mem_err <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22050612_mem_arbiter.sv
// Directed bench for the memory arbiter: inputs driven 1 time unit after each
// rising edge, outputs sampled 1 unit later, memory side played by the tasks.
module tb_ysyx_22050612_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_gnt, if_rvalid;
  logic [63:0] if_addr, if_rdata;
  logic        ls_req, ls_wen, ls_gnt, ls_rvalid;
  logic [63:0] ls_addr, ls_wdata, ls_rdata;
  logic [7:0]  ls_wmask;
  logic        mem_req, mem_wen, mem_gnt, mem_rvalid, mem_err;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_22050612_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_wen(ls_wen), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_wmask(ls_wmask), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .mem_err(mem_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; if_req = 1'b1; if_addr = 64'h10;
    ls_req = 1'b0; ls_wen = 1'b0; ls_addr = '0; ls_wdata = '0; ls_wmask = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    tick(); tick(); #1;
    checks++; if (if_gnt !== 1'b0) begin errors++; $display("FAIL rst_if_gnt: got %b want 0", if_gnt); end
    checks++; if ({mem_req, mem_wen, mem_err} !== 3'b000) begin errors++; $display("FAIL rst_flags: got %b want 000", {mem_req, mem_wen, mem_err}); end
    checks++; if ({mem_addr, mem_wdata, mem_wmask} !== '0) begin errors++; $display("FAIL rst_payload: got %h/%h/%h want 0", mem_addr, mem_wdata, mem_wmask); end
    checks++; if ({if_rvalid, ls_rvalid, ls_gnt} !== 3'b000) begin errors++; $display("FAIL rst_rsp: got %b want 000", {if_rvalid, ls_rvalid, ls_gnt}); end
    if_req = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_single_if_read();
    tick(); if_req = 1'b1; if_addr = 64'h8000_0000; #1;
    checks++; if (if_gnt !== 1'b1) begin errors++; $display("FAIL ifrd_gnt: got %b want 1", if_gnt); end
    tick(); if_req = 1'b0; if_addr = '0; mem_gnt = 1'b1; #1;
    checks++; if ({mem_req, mem_wen, mem_addr, mem_wmask} !== {2'b10, 64'h8000_0000, 8'h00}) begin
      errors++; $display("FAIL ifrd_memreq: got req=%b wen=%b addr=%h mask=%h want 1/0/80000000/00", mem_req, mem_wen, mem_addr, mem_wmask); end
    tick(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h0000_0013_0000_0297; #1;
    checks++; if ({if_rvalid, ls_rvalid} !== 2'b10) begin errors++; $display("FAIL ifrd_rvalid: got if=%b ls=%b want 1/0", if_rvalid, ls_rvalid); end
    checks++; if (if_rdata !== 64'h0000_0013_0000_0297) begin errors++; $display("FAIL ifrd_rdata: got %h want 0000001300000297", if_rdata); end
    checks++; if (ls_rdata !== 64'h0) begin errors++; $display("FAIL ifrd_ls_rdata: got %h want 0", ls_rdata); end
    tick(); mem_rvalid = 1'b0; #1;
    checks++; if ({if_rvalid, mem_req} !== 2'b00) begin errors++; $display("FAIL ifrd_after: got %b want 00", {if_rvalid, mem_req}); end
  endtask

  task automatic test_contention();
    do_reset();
    tick(); if_req = 1'b1; if_addr = 64'h100; ls_req = 1'b1; ls_wen = 1'b0; ls_addr = 64'h200; #1;
    checks++; if ({if_gnt, ls_gnt} !== 2'b10) begin errors++; $display("FAIL cont1_gnt: got if=%b ls=%b want 1/0", if_gnt, ls_gnt); end
    tick(); if_req = 1'b0; mem_gnt = 1'b1; #1;
    checks++; if (ls_gnt !== 1'b0) begin errors++; $display("FAIL cont_req_lsgnt: got %b want 0", ls_gnt); end
    tick(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h1111; #1;
    checks++; if ({if_rvalid, ls_gnt} !== 2'b10) begin errors++; $display("FAIL cont_wait: got rv=%b lsgnt=%b want 1/0", if_rvalid, ls_gnt); end
    tick(); mem_rvalid = 1'b0; #1;
    checks++; if ({if_gnt, ls_gnt} !== 2'b01) begin errors++; $display("FAIL cont2_gnt: got if=%b ls=%b want 0/1", if_gnt, ls_gnt); end
    tick(); ls_req = 1'b0; mem_gnt = 1'b1; #1;
    checks++; if (mem_addr !== 64'h200) begin errors++; $display("FAIL cont2_addr: got %h want 200", mem_addr); end
    tick(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h2222; #1;
    checks++; if ({ls_rvalid, ls_rdata} !== {1'b1, 64'h2222}) begin errors++; $display("FAIL cont2_rsp: got %b/%h want 1/2222", ls_rvalid, ls_rdata); end
    tick(); mem_rvalid = 1'b0; if_req = 1'b1; ls_req = 1'b1; #1;
    checks++; if ({if_gnt, ls_gnt} !== 2'b10) begin errors++; $display("FAIL cont3_gnt: got if=%b ls=%b want 1/0", if_gnt, ls_gnt); end
    tick(); if_req = 1'b0; ls_req = 1'b0; mem_gnt = 1'b1;
    tick(); mem_gnt = 1'b0; mem_rvalid = 1'b1; #1;
    checks++; if (if_rvalid !== 1'b1) begin errors++; $display("FAIL cont3_rsp: got %b want 1", if_rvalid); end
    tick(); mem_rvalid = 1'b0;
  endtask

  task automatic test_ls_write();
    tick(); ls_req = 1'b1; ls_wen = 1'b1; ls_addr = 64'h8000_1004;
    ls_wdata = 64'hDEAD_BEEF_0000_0000; ls_wmask = 8'hF0; #1;
    checks++; if (ls_gnt !== 1'b1) begin errors++; $display("FAIL wr_gnt: got %b want 1", ls_gnt); end
    tick(); ls_req = 1'b0; ls_wen = 1'b0; ls_addr = '0; ls_wdata = '0; ls_wmask = '0; mem_gnt = 1'b1; #1;
    checks++; if ({mem_req, mem_wen, mem_addr, mem_wdata, mem_wmask} !== {2'b11, 64'h8000_1004, 64'hDEAD_BEEF_0000_0000, 8'hF0}) begin
      errors++; $display("FAIL wr_payload: got req=%b wen=%b addr=%h data=%h mask=%h", mem_req, mem_wen, mem_addr, mem_wdata, mem_wmask); end
    tick(); mem_gnt = 1'b0; mem_rvalid = 1'b1; #1;
    checks++; if ({ls_rvalid, if_rvalid} !== 2'b10) begin errors++; $display("FAIL wr_ack: got ls=%b if=%b want 1/0", ls_rvalid, if_rvalid); end
    tick(); mem_rvalid = 1'b0; #1;
    checks++; if (ls_rvalid !== 1'b0) begin errors++; $display("FAIL wr_ack_once: got %b want 0", ls_rvalid); end
  endtask

  task automatic test_back_pressure();
    tick(); if_req = 1'b1; if_addr = 64'h8000_0040; #1;
    checks++; if (if_gnt !== 1'b1) begin errors++; $display("FAIL bp_gnt: got %b want 1", if_gnt); end
    tick(); if_req = 1'b0; if_addr = '0; ls_req = 1'b1; ls_addr = 64'h300;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++; if ({mem_req, mem_addr, ls_gnt, if_gnt} !== {1'b1, 64'h8000_0040, 2'b00}) begin
        errors++; $display("FAIL bp_hold%0d: got req=%b addr=%h lsgnt=%b ifgnt=%b", i, mem_req, mem_addr, ls_gnt, if_gnt); end
      tick();
    end
    mem_gnt = 1'b1;
    tick(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h55; #1;
    checks++; if ({if_rvalid, if_rdata, ls_gnt} !== {1'b1, 64'h55, 1'b0}) begin errors++; $display("FAIL bp_rsp: got %b/%h/%b", if_rvalid, if_rdata, ls_gnt); end
    tick(); mem_rvalid = 1'b0; #1;
    checks++; if (ls_gnt !== 1'b1) begin errors++; $display("FAIL bp_ls_gnt: got %b want 1", ls_gnt); end
    tick(); ls_req = 1'b0; mem_gnt = 1'b1;
    tick(); mem_gnt = 1'b0; mem_rvalid = 1'b1; #1;
    checks++; if (ls_rvalid !== 1'b1) begin errors++; $display("FAIL bp_ls_rsp: got %b want 1", ls_rvalid); end
    tick(); mem_rvalid = 1'b0;
  endtask

  // Grant is cycle 0, mem_gnt at cycle 1; with rvalid_at > 0 a response is
  // offered at exactly that cycle, otherwise memory stays silent.
  task automatic test_timeout(input int rvalid_at, input logic [63:0] rd);
    int c;
    tick(); if_req = 1'b1; if_addr = 64'h8000_0080; #1;
    checks++; if (if_gnt !== 1'b1) begin errors++; $display("FAIL to_gnt: got %b want 1", if_gnt); end
    tick(); if_req = 1'b0; mem_gnt = 1'b1;
    c = 1;
    while (c < 300) begin
      tick(); c++;
      mem_gnt = 1'b0; mem_rvalid = (c == rvalid_at); mem_rdata = rd; #1;
      if (if_rvalid) break;
    end
    checks++; if (c !== 256) begin errors++; $display("FAIL to_cycle: rvalid at cycle %0d want 256", c); end
    checks++; if (if_rdata !== rd) begin errors++; $display("FAIL to_rdata: got %h want %h", if_rdata, rd); end
    tick(); mem_rvalid = 1'b0; #1;
    checks++; if (mem_err !== (rvalid_at == 0)) begin errors++; $display("FAIL to_err: got %b want %b", mem_err, rvalid_at == 0); end
    ls_req = 1'b1; ls_wen = 1'b0; ls_addr = 64'h400; #1;
    checks++; if (ls_gnt !== 1'b1) begin errors++; $display("FAIL to_next_gnt: got %b want 1", ls_gnt); end
    tick(); ls_req = 1'b0; mem_gnt = 1'b1;
    tick(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h77; #1;
    checks++; if ({ls_rvalid, ls_rdata} !== {1'b1, 64'h77}) begin errors++; $display("FAIL to_next_rsp: got %b/%h want 1/77", ls_rvalid, ls_rdata); end
    tick(); mem_rvalid = 1'b0; #1;
    checks++; if (mem_err !== (rvalid_at == 0)) begin errors++; $display("FAIL to_err_sticky: got %b", mem_err); end
  endtask

  task automatic test_reset_mid_wait();
    tick(); if_req = 1'b1; if_addr = 64'h8000_00C0;
    tick(); if_req = 1'b0; mem_gnt = 1'b1;
    tick(); mem_gnt = 1'b0; rst_n = 1'b0; if_req = 1'b1; #1;
    checks++; if ({if_gnt, if_rvalid, mem_req, mem_err} !== 4'b0000) begin errors++; $display("FAIL rmw_in_rst: got %b want 0000", {if_gnt, if_rvalid, mem_req, mem_err}); end
    tick(); rst_n = 1'b1; if_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h99; #1;
    checks++; if ({if_rvalid, ls_rvalid, mem_err, mem_req} !== 4'b0000) begin errors++; $display("FAIL rmw_late: got %b want 0000", {if_rvalid, ls_rvalid, mem_err, mem_req}); end
    checks++; if ({mem_addr, mem_wen, if_rdata} !== '0) begin errors++; $display("FAIL rmw_vals: got addr=%h wen=%b rdata=%h", mem_addr, mem_wen, if_rdata); end
    tick(); mem_rvalid = 1'b0; #1;
    checks++; if ({if_rvalid, mem_req} !== 2'b00) begin errors++; $display("FAIL rmw_after: got %b want 00", {if_rvalid, mem_req}); end
  endtask

  initial begin
    test_reset();
    test_single_if_read();
    test_contention();
    test_ls_write();
    test_back_pressure();
    do_reset();
    test_timeout(256, 64'hABCD);
    test_timeout(0, 64'h0);
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_22050612_mem_arbiter.md
# ysyx_22050612_mem_arbiter

Shares the single data-memory port between the instruction fetch requester (IFU, read-only) and the load/store requester (LSU, read/write). It replaces the current combinational per-cycle memory access with a handshaked, one-outstanding-transaction port. It sits between the IFU/EXU memory interfaces and the memory model or bus bridge. A 2-way round-robin pointer prevents starvation, and a watchdog aborts transactions the memory never answers.

## Interface
- ADDR_W, 64, address width
- DATA_W, 64, data width
- MASK_W, 8, byte-mask width (DATA_W/8)
- TIMEOUT, 255, maximum cycles spent in REQ+WAIT before abort (8-bit counter)

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  IFU read request; held with if_addr stable until if_gnt
- if_addr  in  ADDR_W  IFU read address
- if_gnt  out  1  IFU request accepted this cycle
- if_rvalid  out  1  IFU read data valid, one-cycle pulse
- if_rdata  out  DATA_W  IFU read data
- ls_req  in  1  LSU request; held with payload stable until ls_gnt
- ls_wen  in  1  1 = write, 0 = read
- ls_addr  in  ADDR_W  LSU address
- ls_wdata  in  DATA_W  write data, already lane-aligned
- ls_wmask  in  MASK_W  write byte mask
- ls_gnt  out  1  LSU request accepted this cycle
- ls_rvalid  out  1  read data valid or write acknowledge, one-cycle pulse
- ls_rdata  out  DATA_W  LSU read data; don't-care on write ack
- mem_req  out  1  memory request; held until mem_gnt
- mem_wen, mem_addr, mem_wdata, mem_wmask  out  1/ADDR_W/DATA_W/MASK_W  registered request payload
- mem_gnt  in  1  memory accepted the request
- mem_rvalid  in  1  memory response; legal only from the cycle after mem_gnt
- mem_rdata  in  DATA_W  memory response data
- mem_err  out  1  sticky watchdog-timeout flag

## Operation
- FSM has three states: IDLE, REQ, WAIT. Exactly one transaction is outstanding at a time.
- IDLE:
  - If one requester is asserting req, it wins.
  - If both are asserting req, the requester selected by the priority pointer prio wins (0 = IF, 1 = LS).
  - The winner's gnt is asserted combinationally in that cycle.
  - On the clock edge, the arbiter captures the payload into the mem_* registers, latches owner, sets prio to the non-winner, and goes to REQ.
  - IF transactions always capture mem_wen = 0 and mem_wmask = 0.
- REQ: mem_req = 1. When mem_gnt = 1, go to WAIT. mem_rvalid in REQ is a protocol violation; the arbiter ignores it.
- WAIT: when mem_rvalid = 1, mem_rdata passes combinationally to the owner's rdata and the owner's rvalid pulses for 1 cycle. Next state is IDLE.
- rdata of the non-owner is driven 0.
- Watchdog:
  - An 8-bit counter clears on entry to REQ and increments every cycle in REQ or WAIT.
  - When the counter reaches TIMEOUT, the transaction is aborted: the owner's rvalid pulses with rdata = 0, mem_err is set, and next state is IDLE.
  - A mem_rvalid arriving in the same cycle as the timeout wins: normal completion, no error.
- Requesters must not drop req before gnt. Dropping req while in IDLE simply means no grant.
- A req asserted during REQ or WAIT waits; gnt never asserts outside IDLE.

## Timing
- Reset (async assert, sync-release-safe):
  - State = IDLE, prio = 0 (IF first), owner = IF, counter = 0, mem_err = 0.
  - mem_req, mem_wen, mem_addr, mem_wdata and mem_wmask are all 0.
  - if_gnt, ls_gnt, if_rvalid and ls_rvalid are forced 0 while rst_n = 0.
- Reset mid-transaction drops the transaction silently: no rvalid and no error. A response arriving after reset release is ignored in IDLE.
- Minimum latency, with req at cycle 0:
  - Cycle 0: gnt.
  - Cycle 1: mem_req.
  - Cycle 1: mem_gnt (earliest).
  - Cycle 2: mem_rvalid, giving rvalid at the requester (earliest).
- Back-to-back: the next grant is no earlier than the cycle after rvalid, so peak throughput is 1 transaction per 3 cycles.
- The mem_* payload is stable from the cycle mem_req rises until mem_gnt.

## Structure
- Package ysyx_22050612_mem_pkg holds:
  - the state enum (IDLE, REQ, WAIT);
  - the owner enum (OWN_IF, OWN_LS);
  - localparam defaults for ADDR_W, DATA_W and MASK_W.
- Sub-module ysyx_22050612_rr_arb2 is the 2-way round-robin arbiter.
  - Inputs: clk, rst_n, req[1:0], advance.
  - Output: one-hot gnt[1:0].
  - It owns prio.
- FSM, payload registers, watchdog and response routing live in the top module.

## Test plan
- **Single IF read:** if_req=1, if_addr=0x8000_0000; memory gives mem_gnt at cycle 1 and mem_rvalid at cycle 2 with 0x0000_0013_0000_0297 -> if_gnt at cycle 0, if_rvalid at cycle 2 with that data, ls_rvalid stays 0.
- **Contention after reset:** if_req and ls_req both asserted at cycle 0 -> IF granted first. LSU is granted in the IDLE cycle after if_rvalid. A third simultaneous contention grants IF again, confirming alternation.
- **LSU write:** ls_wen=1, ls_addr=0x8000_1004, ls_wdata=0xDEAD_BEEF_0000_0000, ls_wmask=0xF0 -> mem_* outputs carry exactly those values while mem_req=1. ls_rvalid pulses once on mem_rvalid.
- **Back-pressure:** mem_gnt held low for 10 cycles -> mem_req and payload stay stable for all 10 cycles, and no gnt is given to the other requester.
- **Timeout:** mem_gnt given, mem_rvalid never returns -> after TIMEOUT=255 cycles the owner's rvalid pulses with rdata=0 and mem_err=1 until reset. A subsequent request completes normally.
- **Reset mid-WAIT:** rst_n pulled low for 1 cycle while in WAIT; a late mem_rvalid arrives after release -> no rvalid is produced, mem_err=0, and all outputs are at reset values.
